sram1rw_rr_ctrl: RTL

//  Two-requester controller for one SRAM1RW256x64 single-port macro (1 access/cycle, 1-cycle read latency).

---
 rtl/sram1rw_ctrl_pkg.sv | 18 +
 rtl/rr_arb2.sv | 31 +++
 rtl/sram1rw_rr_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/sram1rw_ctrl_pkg.sv
// Shared types and default geometry for the SRAM1RW256x64 round-robin controller.
package sram1rw_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 256;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority flips only when a grant is actually taken.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset value 1 lets requester 0 win the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/sram1rw_rr_ctrl.sv
// Scrubs a single-port SRAM to INIT_VALUE after reset, then serves two requesters
// round-robin with registered active-low macro strobes and a 2-cycle read response.
module sram1rw_rr_ctrl #(
  parameter int                 ADDR_W     = sram1rw_ctrl_pkg::ADDR_W,
  parameter int                 DATA_W     = sram1rw_ctrl_pkg::DATA_W,
  parameter int                 DEPTH      = sram1rw_ctrl_pkg::DEPTH,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_write,
  input  logic [2*ADDR_W-1:0]  req_addr,
  input  logic [2*DATA_W-1:0]  req_wdata,
  output logic [1:0]           resp_valid,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 init_done,
  output logic                 sram_csb,
  output logic                 sram_web,
  output logic                 sram_oeb,
  output logic [ADDR_W-1:0]    sram_a,
  output logic [DATA_W-1:0]    sram_i,
  input  logic [DATA_W-1:0]    sram_o
);

  import sram1rw_ctrl_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] scrub_cnt;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rsp_entry_t        rsp_s0;
  rsp_entry_t        rsp_s1;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready = {2{init_done}} & grant;
  assign accept    = |req_ready;
  assign sel       = grant[1];
  assign sel_write = sel ? req_write[1] : req_write[0];
  assign sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // Macro data lands in the cycle after it executes; route it to whoever asked.
  assign resp_valid = {rsp_s1.valid & rsp_s1.id, rsp_s1.valid & ~rsp_s1.id};
  assign resp_rdata = sram_o;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      scrub_cnt <= '0;
      init_done <= 1'b0;
      sram_csb  <= 1'b1;
      sram_web  <= 1'b1;
      sram_oeb  <= 1'b1;
      sram_a    <= '0;
      sram_i    <= '0;
      rsp_s0    <= '0;
      rsp_s1    <= '0;
    end else begin
      rsp_s1       <= rsp_s0;
      rsp_s0.valid <= accept & ~sel_write;
      rsp_s0.id    <= sel;
      case (state)
        INIT: begin
          sram_csb  <= 1'b0;
          sram_web  <= 1'b0;
          sram_oeb  <= 1'b1;
          sram_a    <= scrub_cnt;
          sram_i    <= INIT_VALUE;
          scrub_cnt <= scrub_cnt + 1'b1;
          if (scrub_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            sram_csb <= 1'b0;
            sram_web <= ~sel_write;
            sram_oeb <= sel_write;
            sram_a   <= sel_addr;
            sram_i   <= sel_wdata;
          end else begin
            sram_csb <= 1'b1;
            sram_web <= 1'b1;
            sram_oeb <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
